rst_seq_xil7series: RTL and testbench
=====================================

// Module: rst_seq_xil7series
// PURPOSE
// - Reset sequencer on the clk_sys domain. Consumes the raw PLL lock, board reset button, SW reset request
//   and optional watchdog; generates staged, glitch-free system resets.
// - Sits directly after the PLL clock generator: peripheral reset released first, core reset StageGap later.
// - Records the cause of the last reset and counts PLL lock losses.
// PARAMETERS
// - SyncStages     2          flops in each async-input synchroniser (>=2)
// - DebounceCycles 1000       cycles button level must be stable before it is accepted (>=2)
// - HoldCycles     16         min cycles reset stays asserted after all causes clear (>=1)
// - StageGap       8          cycles between rst_periph_n_o and rst_core_n_o release (>=1)
// - WdogCycles     1_000_000  RUN-state cycles without kick before watchdog fires (only with RST_SEQ_WDOG_EN)
// PORTS
// - clk_sys         in   1  system clock
// - rst_sys         in   1  asynchronous, active-high reset (power-on/config)
// - pll_locked_i    in   1  PLL locked, asynchronous
// - ext_rst_ni      in   1  board reset button, asynchronous, active-low
// - sw_rst_req_i    in   1  software reset request, synchronous to clk_sys, sampled every cycle
// - wdog_kick_i     in   1  watchdog kick, synchronous (ignored without RST_SEQ_WDOG_EN)
// - rst_periph_n_o  out  1  peripheral reset, active-low, registered
// - rst_core_n_o    out  1  core reset, active-low, registered
// - rst_active_o    out  1  high whenever state != RUN
// - rst_cause_o     out  4  [0] PLL unlock, [1] button, [2] SW, [3] watchdog
// - lock_loss_cnt_o out  8  saturating count of locked_sync 1->0 transitions
// BEHAVIOUR
// - Reset (rst_sys=1): state=HOLD. rst_periph_n_o=0, rst_core_n_o=0, rst_active_o=1, rst_cause_o=0,
//   lock_loss_cnt_o=0. All counters 0. locked sync chain=0. Button sync chain and debounced level=released.
// - Sync: pll_locked_i and ext_rst_ni each pass through SyncStages flops → locked_sync, btn_sync.
// - Debounce: btn_db changes only after btn_sync differs from btn_db for DebounceCycles consecutive cycles;
//   any return to btn_db clears the counter.
// - cause_vec = {wdog_exp, sw_rst_req_i, btn_db pressed, !locked_sync}. any_cause = |cause_vec.
// - FSM states HOLD, REL_PERIPH, RUN. any_cause has priority over every transition below:
//   - any_cause in any state: next state=HOLD, hold_cnt<=0, both reset outputs <=0 on the same edge.
//     Entering HOLD from REL_PERIPH/RUN: rst_cause_o<=cause_vec. Already in HOLD: rst_cause_o|=cause_vec.
//   - HOLD, no cause: hold_cnt++. When hold_cnt==HoldCycles-1: ->REL_PERIPH, rst_periph_n_o<=1, gap_cnt<=0.
//   - REL_PERIPH, no cause: gap_cnt++. When gap_cnt==StageGap-1: ->RUN, rst_core_n_o<=1.
//   - RUN: both outputs held at 1.
// - Latency: pll_locked_i fall → outputs low after SyncStages+1 edges.
//   Button press → outputs low after SyncStages+DebounceCycles+1 edges.
//   sw_rst_req_i → outputs low on the next edge.
// - Counter widths: $clog2 of the respective parameter. Counters never wrap; they saturate and stop at terminal.
// - lock_loss_cnt_o: +1 on each locked_sync 1->0. Holds at 255. Cleared only by rst_sys.
// - rst_cause_o persists through RUN. It is cleared only by rst_sys.
// - Glitches on async inputs shorter than one clk_sys period have no effect.
// CONFIGURATION
// - RST_SEQ_WDOG_EN defined:
//   - wdog_cnt increments in RUN; cleared by wdog_kick_i or outside RUN.
//   - wdog_exp is a 1-cycle pulse when wdog_cnt==WdogCycles-1 with no kick that cycle.
//   - Kick and expiry in the same cycle: kick wins.
// - RST_SEQ_WDOG_EN undefined: no watchdog logic, wdog_kick_i unused, wdog_exp=0, rst_cause_o[3]=0.
// TESTING
// - Defaults. rst_sys 1->0 with pll_locked_i=1, ext_rst_ni=1:
//   - rst_periph_n_o rises at edge 18 after release; rst_core_n_o at edge 26; rst_cause_o=0001.
// - In RUN, pll_locked_i low for 5 cycles:
//   - outputs low at edge 3, release resumes 16 cycles after locked_sync returns.
//   - rst_cause_o=0001, lock_loss_cnt_o=1.
// - ext_rst_ni pulse of 999 cycles → no reset.
//   Pulse of 1200 cycles → reset asserted at edge 1003, rst_cause_o=0010.
// - sw_rst_req_i pulse in REL_PERIPH → both outputs 0 next edge, hold restarts, rst_cause_o=0100.
//   Simultaneous with button → rst_cause_o=0110.
// - RST_SEQ_WDOG_EN, WdogCycles=100: no kick → reset after 100 RUN cycles with rst_cause_o=1000.
//   Kick every 50 cycles → never fires.
// - Toggle pll_locked_i 300 times → lock_loss_cnt_o saturates at 255. Assert rst_sys mid-HOLD → all outputs at reset values.

Source files
------------

// File: rtl/rst_seq_xil7series.sv
// Reset sequencer for the clk_sys domain.
// Synchronises PLL lock and the board button, debounces the button, and
// releases rst_periph_n_o first and rst_core_n_o StageGap cycles later once
// every reset cause has been quiet for HoldCycles. It keeps a sticky record of
// what caused the last reset and counts PLL lock losses.
// Optional watchdog: define RST_SEQ_WDOG_EN to build it in.
module rst_seq_xil7series #(
  parameter int SyncStages     = 2,
  parameter int DebounceCycles = 1000,
  parameter int HoldCycles     = 16,
  parameter int StageGap       = 8,
  parameter int WdogCycles     = 1_000_000
) (
  input  logic       clk_sys,
  input  logic       rst_sys,
  input  logic       pll_locked_i,
  input  logic       ext_rst_ni,
  input  logic       sw_rst_req_i,
  input  logic       wdog_kick_i,
  output logic       rst_periph_n_o,
  output logic       rst_core_n_o,
  output logic       rst_active_o,
  output logic [3:0] rst_cause_o,
  output logic [7:0] lock_loss_cnt_o
);

  localparam int DbW   = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam int HoldW = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;
  localparam int GapW  = (StageGap > 1) ? $clog2(StageGap) : 1;

  localparam logic [DbW-1:0]   DbLast   = DbW'(DebounceCycles - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HoldCycles - 1);
  localparam logic [GapW-1:0]  GapLast  = GapW'(StageGap - 1);

  typedef enum logic [1:0] {
    HOLD       = 2'd0,
    REL_PERIPH = 2'd1,
    RUN        = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [SyncStages-1:0] lock_sync_q, lock_sync_d;
  logic [SyncStages-1:0] btn_sync_q, btn_sync_d;
  logic                  btn_db_q, btn_db_d;
  logic [DbW-1:0]        db_cnt_q, db_cnt_d;
  logic [HoldW-1:0]      hold_cnt_q, hold_cnt_d;
  logic [GapW-1:0]       gap_cnt_q, gap_cnt_d;
  logic                  periph_n_q, periph_n_d;
  logic                  core_n_q, core_n_d;
  logic [3:0]            cause_q, cause_d;
  logic                  lock_prev_q, lock_prev_d;
  logic [7:0]            lock_cnt_q, lock_cnt_d;

  logic       locked_sync;
  logic       btn_sync;
  logic       wdog_exp;
  logic [3:0] cause_vec;
  logic       any_cause;

  assign locked_sync = lock_sync_q[SyncStages-1];
  assign btn_sync    = btn_sync_q[SyncStages-1];

  // Shift the raw async levels into the synchroniser chains.
  always_comb begin
    lock_sync_d = {lock_sync_q[SyncStages-2:0], pll_locked_i};
    btn_sync_d  = {btn_sync_q[SyncStages-2:0], ext_rst_ni};
  end

  // Accept a new button level only after it has differed for DebounceCycles cycles.
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (btn_sync != btn_db_q) begin
      if (db_cnt_q == DbLast) begin
        btn_db_d = btn_sync;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

`ifdef RST_SEQ_WDOG_EN
  localparam int WdW = (WdogCycles > 1) ? $clog2(WdogCycles) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(WdogCycles - 1);

  logic [WdW-1:0] wdog_cnt_q, wdog_cnt_d;

  // Count unkicked RUN cycles; a kick always beats expiry in the same cycle.
  always_comb begin
    wdog_cnt_d = '0;
    wdog_exp   = 1'b0;
    if ((state_q == RUN) && !wdog_kick_i) begin
      if (wdog_cnt_q == WdLast) begin
        wdog_exp   = 1'b1;
        wdog_cnt_d = wdog_cnt_q;
      end else begin
        wdog_cnt_d = wdog_cnt_q + 1'b1;
      end
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      wdog_cnt_q <= '0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
    end
  end
`else
  logic unused_wdog;
  assign unused_wdog = wdog_kick_i ^ (WdogCycles == 0);
  assign wdog_exp    = 1'b0;
`endif

  assign cause_vec = {wdog_exp, sw_rst_req_i, !btn_db_q, !locked_sync};
  assign any_cause = |cause_vec;

  // Sequencer: any cause forces HOLD, otherwise walk HOLD -> REL_PERIPH -> RUN.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    periph_n_d = periph_n_q;
    core_n_d   = core_n_q;
    cause_d    = cause_q;
    if (any_cause) begin
      state_d    = HOLD;
      hold_cnt_d = '0;
      periph_n_d = 1'b0;
      core_n_d   = 1'b0;
      // A fresh reset replaces the record; causes arriving during HOLD accumulate.
      cause_d    = (state_q == HOLD) ? (cause_q | cause_vec) : cause_vec;
    end else begin
      case (state_q)
        HOLD: begin
          if (hold_cnt_q == HoldLast) begin
            state_d    = REL_PERIPH;
            periph_n_d = 1'b1;
            gap_cnt_d  = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        REL_PERIPH: begin
          if (gap_cnt_q == GapLast) begin
            state_d  = RUN;
            core_n_d = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
        RUN: begin
          periph_n_d = 1'b1;
          core_n_d   = 1'b1;
        end
        default: begin
          state_d    = HOLD;
          hold_cnt_d = '0;
          periph_n_d = 1'b0;
          core_n_d   = 1'b0;
        end
      endcase
    end
  end

  // Saturating count of synchronised lock 1->0 transitions.
  always_comb begin
    lock_prev_d = locked_sync;
    lock_cnt_d  = lock_cnt_q;
    if (lock_prev_q && !locked_sync && (lock_cnt_q != 8'hFF)) begin
      lock_cnt_d = lock_cnt_q + 8'd1;
    end
  end

  // Synchroniser and debounce registers; the button idles released (high).
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      lock_sync_q <= '0;
      btn_sync_q  <= '1;
      btn_db_q    <= 1'b1;
      db_cnt_q    <= '0;
    end else begin
      lock_sync_q <= lock_sync_d;
      btn_sync_q  <= btn_sync_d;
      btn_db_q    <= btn_db_d;
      db_cnt_q    <= db_cnt_d;
    end
  end

  // Sequencer state, reset outputs and cause record.
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state_q    <= HOLD;
      hold_cnt_q <= '0;
      gap_cnt_q  <= '0;
      periph_n_q <= 1'b0;
      core_n_q   <= 1'b0;
      cause_q    <= 4'b0000;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      periph_n_q <= periph_n_d;
      core_n_q   <= core_n_d;
      cause_q    <= cause_d;
    end
  end

  // Lock-loss edge detector and counter registers.
  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      lock_prev_q <= 1'b0;
      lock_cnt_q  <= 8'd0;
    end else begin
      lock_prev_q <= lock_prev_d;
      lock_cnt_q  <= lock_cnt_d;
    end
  end

  assign rst_periph_n_o  = periph_n_q;
  assign rst_core_n_o    = core_n_q;
  assign rst_active_o    = (state_q != RUN);
  assign rst_cause_o     = cause_q;
  assign lock_loss_cnt_o = lock_cnt_q;

endmodule

// File: tb/tb_rst_seq_xil7series.sv
// Self-checking bench for rst_seq_xil7series: directed scenarios with literal
// timing expectations, then randomized traffic against a behavioural model
// that tracks "edges since the last reset cause" instead of FSM states.
module tb_rst_seq_xil7series;

  localparam int S = 2;
  localparam int D = 1000;
  localparam int H = 16;
  localparam int G = 8;
  localparam int W = 100;

  logic       clk_sys = 1'b0;
  logic       rst_sys = 1'b0;
  logic       pll_locked_i = 1'b1;
  logic       ext_rst_ni = 1'b1;
  logic       sw_rst_req_i = 1'b0;
  logic       wdog_kick_i = 1'b0;
  logic       rst_periph_n_o;
  logic       rst_core_n_o;
  logic       rst_active_o;
  logic [3:0] rst_cause_o;
  logic [7:0] lock_loss_cnt_o;

  int errors = 0;
  int checks = 0;
  bit auto_kick = 1'b1;
  int kick_phase = 0;

  always #5 clk_sys = ~clk_sys;

  rst_seq_xil7series #(
    .SyncStages(S), .DebounceCycles(D), .HoldCycles(H), .StageGap(G), .WdogCycles(W)
  ) dut (
    .clk_sys(clk_sys), .rst_sys(rst_sys), .pll_locked_i(pll_locked_i),
    .ext_rst_ni(ext_rst_ni), .sw_rst_req_i(sw_rst_req_i), .wdog_kick_i(wdog_kick_i),
    .rst_periph_n_o(rst_periph_n_o), .rst_core_n_o(rst_core_n_o),
    .rst_active_o(rst_active_o), .rst_cause_o(rst_cause_o),
    .lock_loss_cnt_o(lock_loss_cnt_o)
  );

  // Behavioural model state: input sample histories, debounced level,
  // quiet = consecutive edges with no cause (saturates at H+G), runq = consecutive
  // unkicked RUN edges, sticky cause, lock-loss count.
  bit       m_lhist[S];
  bit       m_bhist[S];
  bit       m_db;
  int       m_dlen;
  int       m_quiet;
  int       m_runq;
  bit       m_lprev;
  int       m_cnt;
  bit [3:0] m_cause;

  function automatic int m_periph(); return (m_quiet >= H) ? 1 : 0; endfunction
  function automatic int m_core();   return (m_quiet >= H + G) ? 1 : 0; endfunction
  function automatic int m_active(); return (m_quiet < H + G) ? 1 : 0; endfunction

  task automatic m_reset();
    for (int i = 0; i < S; i++) begin
      m_lhist[i] = 1'b0;
      m_bhist[i] = 1'b1;
    end
    m_db = 1'b1; m_dlen = 0; m_quiet = 0; m_runq = 0;
    m_lprev = 1'b0; m_cnt = 0; m_cause = 4'b0000;
  endtask

  task automatic m_step();
    bit ls, bs, wexp, in_hold, in_run;
    bit [3:0] vec;
    ls = m_lhist[S-1];
    bs = m_bhist[S-1];
    in_hold = (m_quiet < H);
    in_run  = (m_quiet >= H + G);
    wexp = 1'b0;
`ifdef RST_SEQ_WDOG_EN
    wexp = in_run && !wdog_kick_i && (m_runq >= W - 1);
    if (in_run && !wdog_kick_i) m_runq++;
    else m_runq = 0;
`endif
    vec = {wexp, sw_rst_req_i, !m_db, !ls};
    if (vec != 4'b0000) begin
      m_cause = in_hold ? (m_cause | vec) : vec;
      m_quiet = 0;
    end else if (m_quiet < H + G) begin
      m_quiet++;
    end
    if (!ls && m_lprev && m_cnt < 255) m_cnt++;
    m_lprev = ls;
    if (bs != m_db) begin
      m_dlen++;
      if (m_dlen == D) begin
        m_db = bs;
        m_dlen = 0;
      end
    end else begin
      m_dlen = 0;
    end
    for (int i = S - 1; i > 0; i--) begin
      m_lhist[i] = m_lhist[i-1];
      m_bhist[i] = m_bhist[i-1];
    end
    m_lhist[0] = pll_locked_i;
    m_bhist[0] = ext_rst_ni;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk_sys or posedge rst_sys);
      if (rst_sys) m_reset();
      else m_step();
    end
  end

  task automatic check(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (!rst_sys) begin
        check("periph", int'(rst_periph_n_o), m_periph());
        check("core", int'(rst_core_n_o), m_core());
        check("active", int'(rst_active_o), m_active());
        check("cause", int'(rst_cause_o), int'(m_cause));
        check("lockcnt", int'(lock_loss_cnt_o), m_cnt);
      end
    end
  end

  task automatic lit(input string nm, input int dutv, input int mdlv, input int expv);
    check({nm, "_dut"}, dutv, expv);
    check({nm, "_mdl"}, mdlv, expv);
  endtask

  task automatic lit_p(input string nm, input int e);  lit(nm, int'(rst_periph_n_o), m_periph(), e); endtask
  task automatic lit_c(input string nm, input int e);  lit(nm, int'(rst_core_n_o), m_core(), e); endtask
  task automatic lit_a(input string nm, input int e);  lit(nm, int'(rst_active_o), m_active(), e); endtask
  task automatic lit_rc(input string nm, input int e); lit(nm, int'(rst_cause_o), int'(m_cause), e); endtask
  task automatic lit_n(input string nm, input int e);  lit(nm, int'(lock_loss_cnt_o), m_cnt, e); endtask

  task automatic chk_reset(input string nm);
    check({nm, "_periph"}, int'(rst_periph_n_o), 0);
    check({nm, "_core"}, int'(rst_core_n_o), 0);
    check({nm, "_active"}, int'(rst_active_o), 1);
    check({nm, "_cause"}, int'(rst_cause_o), 0);
    check({nm, "_cnt"}, int'(lock_loss_cnt_o), 0);
  endtask

  // Advance n rising edges, stopping at the following falling edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      @(negedge clk_sys);
      if (auto_kick) begin
        kick_phase++;
        wdog_kick_i = ((kick_phase % 50) == 0);
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int pll_left;
    int btn_left;
    #1 rst_sys = 1'b1;
    cyc(3);
    chk_reset("por");

    // Power-on release.
    rst_sys = 1'b0;
    cyc(17); lit_p("rel_p17", 0);
    cyc(1);  lit_p("rel_p18", 1); lit_c("rel_c18", 0);
    cyc(7);  lit_c("rel_c25", 0);
    cyc(1);  lit_c("rel_c26", 1); lit_a("rel_a26", 0);
    lit_rc("rel_cause", 1); lit_n("rel_cnt", 0);

    // Lock lost for 5 cycles.
    cyc(10);
    pll_locked_i = 1'b0;
    cyc(2); lit_p("ll_p2", 1);
    cyc(1); lit_p("ll_p3", 0); lit_c("ll_c3", 0); lit_n("ll_cnt3", 1);
    cyc(2); pll_locked_i = 1'b1;
    cyc(17); lit_p("ll_p22", 0);
    cyc(1);  lit_p("ll_p23", 1); lit_rc("ll_cause", 1); lit_n("ll_cnt", 1);
    cyc(12);

    // Sub-cycle glitches on async inputs.
    #1 pll_locked_i = 1'b0; ext_rst_ni = 1'b0;
    #2 pll_locked_i = 1'b1; ext_rst_ni = 1'b1;
    cyc(5); lit_c("glitch_c", 1); lit_n("glitch_cnt", 1);

    // 999-cycle button press is rejected.
    ext_rst_ni = 1'b0; cyc(999); ext_rst_ni = 1'b1;
    cyc(1010); lit_c("btn999_c", 1); lit_rc("btn999_cause", 1);

    // 1200-cycle button press.
    ext_rst_ni = 1'b0;
    cyc(1002); lit_p("btn_p1002", 1);
    cyc(1);    lit_p("btn_p1003", 0); lit_c("btn_c1003", 0); lit_rc("btn_cause", 2);
    cyc(197);  ext_rst_ni = 1'b1;
    cyc(1040); lit_c("btn_back", 1);

    // Software request in RUN, then again in REL_PERIPH.
    sw_rst_req_i = 1'b1; cyc(1); sw_rst_req_i = 1'b0;
    lit_p("sw1_p", 0); lit_c("sw1_c", 0); lit_rc("sw1_cause", 4);
    cyc(15); lit_p("sw1_p15", 0);
    cyc(1);  lit_p("sw1_p16", 1); lit_c("sw1_c16", 0);
    cyc(3);
    sw_rst_req_i = 1'b1; cyc(1); sw_rst_req_i = 1'b0;
    lit_p("sw2_p", 0); lit_c("sw2_c", 0); lit_rc("sw2_cause", 4);
    cyc(15); lit_p("sw2_p15", 0);
    cyc(1);  lit_p("sw2_p16", 1);
    cyc(8);  lit_c("sw2_c24", 1);
    cyc(4);

    // Software request on the same edge the debounced press appears.
    ext_rst_ni = 1'b0;
    cyc(1002); lit_p("both_p1002", 1);
    sw_rst_req_i = 1'b1; cyc(1); sw_rst_req_i = 1'b0;
    lit_rc("both_cause", 6); lit_p("both_p", 0); lit_c("both_c", 0);
    cyc(10); ext_rst_ni = 1'b1;
    cyc(1040); lit_c("both_back", 1);

    // Watchdog with no kicks.
    auto_kick = 1'b0; wdog_kick_i = 1'b0;
    sw_rst_req_i = 1'b1; cyc(1); sw_rst_req_i = 1'b0;
    lit_rc("wd_sw_cause", 4);
    cyc(123); lit_c("wd_c124", 1); lit_p("wd_p124", 1);
    cyc(1);
`ifdef RST_SEQ_WDOG_EN
    lit_c("wd_c125", 0); lit_p("wd_p125", 0); lit_rc("wd_cause", 8);
    auto_kick = 1'b1; kick_phase = 0;
    cyc(430); lit_c("wd_kick_c", 1); lit_rc("wd_kick_cause", 8);
`else
    lit_c("wd_c125", 1); lit_rc("wd_cause", 4);
    auto_kick = 1'b1; kick_phase = 0;
    cyc(30);
`endif

    // Lock-loss counter saturation.
    for (int i = 0; i < 300; i++) begin
      pll_locked_i = 1'b0; cyc(2);
      pll_locked_i = 1'b1; cyc(2);
      if (i == 99) lit_n("cnt_101", 101);
    end
    lit_n("cnt_sat", 255);
    cyc(5); lit_a("mid_hold_a", 1); lit_p("mid_hold_p", 0);
    rst_sys = 1'b1;
    #1 chk_reset("hold_rst");
    cyc(2); chk_reset("hold_rst2");
    rst_sys = 1'b0;

    // Randomized traffic.
    auto_kick = 1'b0;
    pll_left = 0;
    btn_left = 0;
    for (int c = 0; c < 15000; c++) begin
      if (pll_left == 0 && $urandom_range(0, 599) == 0) pll_left = $urandom_range(1, 8);
      if (btn_left == 0 && $urandom_range(0, 2999) == 0) btn_left = $urandom_range(990, 1010);
      pll_locked_i = (pll_left == 0);
      if (pll_left > 0) pll_left--;
      ext_rst_ni = (btn_left == 0) && ($urandom_range(0, 299) != 0);
      if (btn_left > 0) btn_left--;
      sw_rst_req_i = ($urandom_range(0, 1999) == 0);
      wdog_kick_i = ($urandom_range(0, 69) == 0);
      if ($urandom_range(0, 99) == 0) begin
        #1 pll_locked_i = ~pll_locked_i;
        #2 pll_locked_i = ~pll_locked_i;
      end
      if ($urandom_range(0, 4999) == 0) begin
        rst_sys = 1'b1; cyc(2); rst_sys = 1'b0;
      end
      cyc(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
